// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data SRAM between the MEM-stage CPU port and an external loader/debug port.
// Grant is combinational, read data returns one cycle later; CPU is stalled when EXT wins (EXT never starves).
module dmem_port_arbiter #(
  parameter int WIDTH        = 32,
  parameter int AW           = 11,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [AW-1:0]    cpu_addr,
  input  logic [WIDTH-1:0] cpu_wdata,
  output logic [WIDTH-1:0] cpu_rdata,
  output logic             cpu_stall,
  input  logic             ext_req,
  input  logic             ext_we,
  input  logic [AW-1:0]    ext_addr,
  input  logic [WIDTH-1:0] ext_wdata,
  output logic             ext_gnt,
  output logic             ext_rvalid,
  output logic [WIDTH-1:0] ext_rdata,
  output logic [AW-1:0]    mem_a,
  output logic [WIDTH-1:0] mem_d,
  output logic             mem_wen,
  input  logic [WIDTH-1:0] mem_q
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_EXT  = 2'd2
  } owner_t;

  logic [CW-1:0] wait_cnt;
  owner_t        owner;
  owner_t        owner_nxt;
  logic          force_ext;
  logic          ext_win;
  logic          cpu_win;

  // Grants are suppressed while rst is held so the SRAM sees no access during reset.
  assign force_ext = ext_req && (wait_cnt == LIMIT);
  assign ext_win   = !rst && ext_req && (!cpu_req || force_ext);
  assign cpu_win   = !rst && cpu_req && !ext_win;

  assign ext_gnt   = ext_win;
  assign cpu_stall = cpu_req && ext_win;

  assign mem_a   = ext_win ? ext_addr  : cpu_addr;
  assign mem_d   = ext_win ? ext_wdata : cpu_wdata;
  assign mem_wen = ~((ext_win && ext_we) || (cpu_win && cpu_we));

  assign cpu_rdata = mem_q;
  assign ext_rdata = mem_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (!ext_req || ext_win) begin
      wait_cnt <= '0;
    end else if (wait_cnt != LIMIT) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner <= OWN_NONE;
    end else begin
      owner <= owner_nxt;
    end
  end

  always_comb begin
    owner_nxt = OWN_NONE;
    if (ext_win && !ext_we) begin
      owner_nxt = OWN_EXT;
    end else if (cpu_win && !cpu_we) begin
      owner_nxt = OWN_CPU;
    end
  end

  always_comb begin
    ext_rvalid = 1'b0;
    if (owner == OWN_EXT) begin
      ext_rvalid = 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: SRAM model, directed table, corner sequences and a randomized scoreboard.
module tb_dmem_port_arbiter;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [10:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        ext_req = 1'b0, ext_we = 1'b0;
  logic [10:0] ext_addr = '0;
  logic [31:0] ext_wdata = '0;
  logic        ext_gnt, ext_rvalid;
  logic [31:0] ext_rdata;
  logic [10:0] mem_a;
  logic [31:0] mem_d;
  logic        mem_wen;
  logic [31:0] mem_q = '0;

  logic [31:0] sram    [0:2047];
  logic [31:0] ref_mem [0:2047];

  int checks = 0;
  int failures = 0;

  // Reference state: starvation counter, who owns the next read return, and its data.
  int          m_wait = 0;
  int          m_own = 0;
  logic [31:0] m_pdata = '0;
  logic        m_egnt, m_stall;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!mem_wen) sram[mem_a] <= mem_d;
    mem_q <= sram[mem_a];
  end

  dmem_port_arbiter #(.WIDTH(32), .AW(11), .STARVE_LIMIT(L)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_a(mem_a), .mem_d(mem_d), .mem_wen(mem_wen), .mem_q(mem_q)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs, compare against the reference, then advance the reference.
  task automatic cycle(input logic cr, input logic cw, input logic [10:0] ca, input logic [31:0] cd,
                       input logic er, input logic ew, input logic [10:0] ea, input logic [31:0] ed);
    logic xw, cwin, wr;
    logic [10:0] pa;
    logic [31:0] pd;
    @(negedge clk);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    ext_req = er; ext_we = ew; ext_addr = ea; ext_wdata = ed;
    #1;
    xw   = er && (!cr || (m_wait == L));
    cwin = cr && !xw;
    wr   = (xw && ew) || (cwin && cw);
    pa   = xw ? ea : ca;
    pd   = xw ? ed : cd;
    chk("ext_gnt", {31'd0, ext_gnt}, {31'd0, xw});
    chk("cpu_stall", {31'd0, cpu_stall}, {31'd0, cr && xw});
    chk("mem_wen", {31'd0, mem_wen}, {31'd0, !wr});
    chk("mem_a", {21'd0, mem_a}, {21'd0, pa});
    if (wr) chk("mem_d", mem_d, pd);
    chk("ext_rvalid", {31'd0, ext_rvalid}, {31'd0, m_own == 2});
    if (m_own == 2) chk("ext_rdata", ext_rdata, m_pdata);
    if (m_own == 1) chk("cpu_rdata", cpu_rdata, m_pdata);
    m_pdata = ref_mem[pa];
    m_own   = (xw && !ew) ? 2 : (cwin && !cw) ? 1 : 0;
    if (wr) ref_mem[pa] = pd;
    m_wait  = (!er || xw) ? 0 : ((m_wait < L) ? m_wait + 1 : L);
    m_egnt  = xw;
    m_stall = cr && xw;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 11'd0, 32'd0, 1'b0, 1'b0, 11'd0, 32'd0);
  endtask

  typedef struct {
    logic cr, cw, er, ew;
    logic eg, es, wen;
  } vec_t;

  function automatic logic [10:0] pick_addr();
    return ($urandom_range(0, 7) == 0) ? 11'h7FF : 11'($urandom_range(0, 15));
  endfunction

  initial begin
    vec_t vecs [13];
    logic cr, cw, er, ew;
    logic [10:0] ca, ea;
    logic [31:0] cd, ed;
    logic c_hold, e_hold;

    for (int i = 0; i < 2048; i++) begin
      sram[i]    = (i * 32'h01000193) ^ 32'h5A5A0000;
      ref_mem[i] = (i * 32'h01000193) ^ 32'h5A5A0000;
    end
    sram[16]    = 32'h12345678;
    ref_mem[16] = 32'h12345678;

    // Reset state with both requests high.
    cpu_req = 1'b1; ext_req = 1'b1;
    #2;
    chk("rst_ext_gnt", {31'd0, ext_gnt}, 32'd0);
    chk("rst_cpu_stall", {31'd0, cpu_stall}, 32'd0);
    chk("rst_mem_wen", {31'd0, mem_wen}, 32'd1);
    chk("rst_ext_rvalid", {31'd0, ext_rvalid}, 32'd0);
    cpu_req = 1'b0; ext_req = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Contention table: {cpu_req, cpu_we, ext_req, ext_we, ext_gnt, cpu_stall, mem_wen}.
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 13; i++) begin
      cycle(vecs[i].cr, vecs[i].cw, 11'h100, 32'hC0DE0000 + i,
            vecs[i].er, vecs[i].ew, 11'h101, 32'hE0E00000 + i);
      chk($sformatf("vec%0d_gnt", i), {31'd0, ext_gnt}, {31'd0, vecs[i].eg});
      chk($sformatf("vec%0d_stall", i), {31'd0, cpu_stall}, {31'd0, vecs[i].es});
      chk($sformatf("vec%0d_wen", i), {31'd0, mem_wen}, {31'd0, vecs[i].wen});
    end
    idle();

    // CPU write then read of 0x005.
    cycle(1'b1, 1'b1, 11'h005, 32'hDEADBEEF, 1'b0, 1'b0, 11'd0, 32'd0);
    chk("t1_wen", {31'd0, mem_wen}, 32'd0);
    cycle(1'b1, 1'b0, 11'h005, 32'd0, 1'b0, 1'b0, 11'd0, 32'd0);
    chk("t1_stall", {31'd0, cpu_stall}, 32'd0);
    idle();
    chk("t1_rdata", cpu_rdata, 32'hDEADBEEF);

    // EXT read of preloaded 0x010: one-cycle rvalid pulse.
    cycle(1'b0, 1'b0, 11'd0, 32'd0, 1'b1, 1'b0, 11'h010, 32'd0);
    chk("t2_gnt", {31'd0, ext_gnt}, 32'd1);
    idle();
    chk("t2_rvalid", {31'd0, ext_rvalid}, 32'd1);
    chk("t2_rdata", ext_rdata, 32'h12345678);
    idle();
    chk("t2_rvalid_drop", {31'd0, ext_rvalid}, 32'd0);

    // EXT writes top address, CPU reads it back.
    cycle(1'b0, 1'b0, 11'd0, 32'd0, 1'b1, 1'b1, 11'h7FF, 32'hA5A5A5A5);
    cycle(1'b1, 1'b0, 11'h7FF, 32'd0, 1'b0, 1'b0, 11'd0, 32'd0);
    idle();
    chk("t6_rdata", cpu_rdata, 32'hA5A5A5A5);

    // Reset arriving the cycle after an EXT read grant discards the return.
    cycle(1'b0, 1'b0, 11'd0, 32'd0, 1'b1, 1'b0, 11'h010, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1;
    #1;
    chk("t5_rvalid", {31'd0, ext_rvalid}, 32'd0);
    chk("t5_gnt", {31'd0, ext_gnt}, 32'd0);
    chk("t5_stall", {31'd0, cpu_stall}, 32'd0);
    chk("t5_wen", {31'd0, mem_wen}, 32'd1);
    @(posedge clk);
    #1;
    chk("t5_rvalid_hold", {31'd0, ext_rvalid}, 32'd0);
    @(negedge clk);
    cpu_req = 1'b0; cpu_we = 1'b0; ext_req = 1'b0;
    rst = 1'b0;
    m_wait = 0; m_own = 0;
    idle();
    chk("t5_rvalid_after", {31'd0, ext_rvalid}, 32'd0);

    // Randomized traffic obeying the hold-until-accepted rules of both ports.
    c_hold = 1'b0; e_hold = 1'b0;
    cr = 1'b0; cw = 1'b0; ca = '0; cd = '0;
    er = 1'b0; ew = 1'b0; ea = '0; ed = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!c_hold) begin
        cr = ($urandom_range(0, 99) < 60);
        cw = $urandom_range(0, 1) == 1;
        ca = pick_addr();
        cd = $urandom;
      end
      if (!e_hold) begin
        er = ($urandom_range(0, 99) < 45);
        ew = $urandom_range(0, 1) == 1;
        ea = pick_addr();
        ed = $urandom;
      end
      cycle(cr, cw, ca, cd, er, ew, ea, ed);
      c_hold = m_stall;
      e_hold = er && !m_egnt;
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
